inst_immediate_decode: RTL and testbench
========================================

// Module: inst_immediate_decode
// PURPOSE
//  Combinational RV32I immediate extractor in the decode stage. Forms all five
//  immediates (I/S/B/U/J) from a 32-bit instruction word. Also outputs the one
//  immediate implied by the opcode, plus a format tag, for the ALU operand mux.
// PARAMETERS
//  none (XLEN fixed at 32)
// PORTS
//  clk          in   1   clock; the block has one clock; used only with IMM_DECODE_REG_EN
//  rst_n        in   1   reset, asynchronous, active-low; used only with IMM_DECODE_REG_EN
//  inst         in   32  instruction word
//  I_immediate  out  32  I-type immediate
//  S_immediate  out  32  S-type immediate
//  B_immediate  out  32  B-type immediate
//  U_immediate  out  32  U-type immediate
//  J_immediate  out  32  J-type immediate
//  imm          out  32  immediate selected by opcode
//  imm_fmt      out  3   imm_fmt_e: NONE=0, I=1, S=2, B=3, U=4, J=5
// BEHAVIOUR
//  I = {{21{inst[31]}}, inst[30:20]}
//  S = {{21{inst[31]}}, inst[30:25], inst[11:7]}
//  B = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}   bit0 always 0
//  U = {inst[31:12], 12'b0}                                       bits 11:0 always 0
//  J = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} bit0 always 0
//  - Sign bit is always inst[31]; no dependence on opcode for the five outputs.
//  - Selection by inst[6:0]:
//    - 0110111 LUI, 0010111 AUIPC -> U
//    - 1101111 JAL -> J
//    - 1100011 BRANCH -> B
//    - 0100011 STORE -> S
//    - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM -> I
//    - any other opcode (incl. OP 0110011) -> imm=0, imm_fmt=NONE
//  - Shift-immediates (SLLI/SRLI/SRAI) receive the plain I immediate; shamt and
//    funct7 are separated downstream.
//  - Default build: purely combinational, zero latency, no state. clk and rst_n
//    are unused and carry a lint waiver.
//  - No X propagation: every output is fully defined for every inst value.
// CONFIGURATION
//  IMM_DECODE_REG_EN defined:
//    - All seven outputs registered on posedge clk; latency 1 cycle.
//    - rst_n low clears all outputs to 0 and imm_fmt to NONE asynchronously,
//      including mid-stream; first valid output is the cycle after rst_n rises.
//  IMM_DECODE_REG_EN undefined: outputs follow inst combinationally.
// STRUCTURE
//  - Package imm_decode_pkg holds:
//    - imm_fmt_e enum
//    - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
//      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_SYSTEM
//  - Sub-module imm_fmt_select: opcode -> imm_fmt_e plus the final mux.
//  - Top level holds the field extraction and the optional output register.
// TESTING
//  - inst=32'h8000_0000 -> I=S=FFFF_F800, B=FFFF_F000, U=8000_0000, J=FFF0_0000
//  - inst=32'hFFFF_FFFF -> I=S=FFFF_FFFF, B=J=FFFF_FFFE, U=FFFF_F000; imm_fmt=NONE
//  - inst=32'h0010_0000 -> I=0000_0001, J=0000_0800, S=B=0, U=0010_0000
//  - inst=32'h0000_0080 -> S=0000_0001, B=0000_0800, I=0; inst=32'h000F_F000 -> U=J=000F_F000
//  - Opcode sweep:
//    - inst=32'hFFF0_0093 (ADDI -1) -> imm=FFFF_FFFF, imm_fmt=I
//    - 32'h1234_5037 (LUI) -> imm=1234_5000, imm_fmt=U
//  - With IMM_DECODE_REG_EN:
//    - rst_n low -> all outputs 0
//    - an inst change appears on the outputs exactly one clk edge later
//    - rst_n asserted mid-stream clears the outputs immediately

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared types for the RV32I immediate decoder: format tag enum and base opcodes.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_fmt_select.sv
// Maps the opcode to an immediate format tag and picks the matching immediate.
module imm_fmt_select
  import imm_decode_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] i_imm,
  input  logic [31:0] s_imm,
  input  logic [31:0] b_imm,
  input  logic [31:0] u_imm,
  input  logic [31:0] j_imm,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  always_comb begin
    fmt = FMT_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      OPC_BRANCH:                                fmt = FMT_B;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      default:                                   fmt = FMT_NONE;
    endcase
  end

  // Opcodes without an immediate (e.g. OP) drive zero rather than a stale field.
  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I:   imm = i_imm;
      FMT_S:   imm = s_imm;
      FMT_B:   imm = b_imm;
      FMT_U:   imm = u_imm;
      FMT_J:   imm = j_imm;
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/inst_immediate_decode.sv
// RV32I immediate extraction for decode; all five immediates plus the opcode-selected one.
// Define IMM_DECODE_REG_EN to register every output (1-cycle latency, async active-low clear).
module inst_immediate_decode
  import imm_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic [31:0] I_immediate,
  output logic [31:0] S_immediate,
  output logic [31:0] B_immediate,
  output logic [31:0] U_immediate,
  output logic [31:0] J_immediate,
  output logic [31:0] imm,
  output logic [2:0]  imm_fmt
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [31:0] sel_imm;
  imm_fmt_e    sel_fmt;

  // Sign always comes from inst[31], independent of opcode.
  always_comb begin
    i_imm = {{21{inst[31]}}, inst[30:20]};
    s_imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm = {inst[31:12], 12'b0};
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  end

  imm_fmt_select u_fmt_select (
    .opcode (inst[6:0]),
    .i_imm  (i_imm),
    .s_imm  (s_imm),
    .b_imm  (b_imm),
    .u_imm  (u_imm),
    .j_imm  (j_imm),
    .imm    (sel_imm),
    .fmt    (sel_fmt)
  );

`ifdef IMM_DECODE_REG_EN
  logic [31:0] i_q;
  logic [31:0] s_q;
  logic [31:0] b_q;
  logic [31:0] u_q;
  logic [31:0] j_q;
  logic [31:0] imm_q;
  imm_fmt_e    fmt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q   <= 32'd0;
      s_q   <= 32'd0;
      b_q   <= 32'd0;
      u_q   <= 32'd0;
      j_q   <= 32'd0;
      imm_q <= 32'd0;
      fmt_q <= FMT_NONE;
    end else begin
      i_q   <= i_imm;
      s_q   <= s_imm;
      b_q   <= b_imm;
      u_q   <= u_imm;
      j_q   <= j_imm;
      imm_q <= sel_imm;
      fmt_q <= sel_fmt;
    end
  end

  assign I_immediate = i_q;
  assign S_immediate = s_q;
  assign B_immediate = b_q;
  assign U_immediate = u_q;
  assign J_immediate = j_q;
  assign imm         = imm_q;
  assign imm_fmt     = fmt_q;
`else
  // Combinational build: clock and reset are intentionally unconsumed.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign I_immediate = i_imm;
  assign S_immediate = s_imm;
  assign B_immediate = b_imm;
  assign U_immediate = u_imm;
  assign J_immediate = j_imm;
  assign imm         = sel_imm;
  assign imm_fmt     = sel_fmt;
`endif

endmodule

// File: tb/tb_inst_immediate_decode.sv
// Self-checking bench for inst_immediate_decode; handles both the combinational and
// the IMM_DECODE_REG_EN registered build.
module tb_inst_immediate_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'd0;
  logic [31:0] I_immediate, S_immediate, B_immediate, U_immediate, J_immediate, imm;
  logic [2:0]  imm_fmt;

  inst_immediate_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst        (inst),
    .I_immediate (I_immediate),
    .S_immediate (S_immediate),
    .B_immediate (B_immediate),
    .U_immediate (U_immediate),
    .J_immediate (J_immediate),
    .imm         (imm),
    .imm_fmt     (imm_fmt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] i, s, b, u, j, imm;
    logic [2:0]  fmt;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] fmt_of(input logic [6:0] opc);
    case (opc)
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h63:                      return 3'd3;
      7'h23:                      return 3'd2;
      7'h03, 7'h13, 7'h67, 7'h73: return 3'd1;
      default:                    return 3'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] x);
    exp_t e;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    s12 = {x[31:25], x[11:7]};
    b13 = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    j21 = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    e.inst = x;
    e.i    = 32'($signed(x) >>> 20);
    e.s    = {{20{s12[11]}}, s12};
    e.b    = {{19{b13[12]}}, b13};
    e.u    = x & 32'hFFFF_F000;
    e.j    = {{11{j21[20]}}, j21};
    e.fmt  = fmt_of(x[6:0]);
    case (e.fmt)
      3'd1:    e.imm = e.i;
      3'd2:    e.imm = e.s;
      3'd3:    e.imm = e.b;
      3'd4:    e.imm = e.u;
      3'd5:    e.imm = e.j;
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] x, input logic [31:0] i, input logic [31:0] s,
                              input logic [31:0] b, input logic [31:0] u, input logic [31:0] j,
                              input logic [31:0] im, input logic [2:0] f);
    exp_t e;
    e.inst = x; e.i = i; e.s = s; e.b = b; e.u = u; e.j = j; e.imm = im; e.fmt = f;
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " I"},   I_immediate, e.i);
    check({tag, " S"},   S_immediate, e.s);
    check({tag, " B"},   B_immediate, e.b);
    check({tag, " U"},   U_immediate, e.u);
    check({tag, " J"},   J_immediate, e.j);
    check({tag, " imm"}, imm,         e.imm);
    check({tag, " fmt"}, {29'd0, imm_fmt}, {29'd0, e.fmt});
  endtask

  // Called at a negedge: drive, then compare one cycle later against the popped entry.
  task automatic apply(input exp_t e);
    exp_t got_e;
    inst = e.inst;
    sb.push_back(e);
`ifdef IMM_DECODE_REG_EN
    #1;
    check("hold before edge imm", imm, prev.imm);
`endif
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard empty", 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      check_all($sformatf("inst=%h", got_e.inst), got_e);
      prev = got_e;
    end
  endtask

  localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                       7'h23, 7'h13, 7'h73, 7'h33, 7'h0F};

  exp_t zero_e;

  initial begin
    zero_e = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
`ifdef IMM_DECODE_REG_EN
    inst = 32'hFFFF_FFFF;
`else
    inst = 32'd0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", zero_e);
    rst_n = 1'b1;
    prev = zero_e;

    apply(mk(32'h8000_0000, 32'hFFFF_F800, 32'hFFFF_F800, 32'hFFFF_F000, 32'h8000_0000,
             32'hFFF0_0000, 32'd0, 3'd0));
    apply(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_F000,
             32'hFFFF_FFFE, 32'd0, 3'd0));
    apply(mk(32'h0010_0000, 32'h0000_0001, 32'd0, 32'd0, 32'h0010_0000,
             32'h0000_0800, 32'd0, 3'd0));
    apply(mk(32'h0000_0080, 32'd0, 32'h0000_0001, 32'h0000_0800, 32'd0,
             32'd0, 32'd0, 3'd0));
    apply(mk(32'h000F_F000, 32'd0, 32'd0, 32'd0, 32'h000F_F000,
             32'h000F_F000, 32'd0, 3'd0));
    apply(mk(32'h1234_5037, 32'h0000_0123, 32'h0000_0120, 32'h0000_0120, 32'h1234_5000,
             32'h0004_5922, 32'h1234_5000, 3'd4));
    apply(mk(32'hFFF0_0093, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'hFFFF_FFE0, 32'hFFF0_0000,
             32'hFFF0_0FFE, 32'hFFFF_FFFF, 3'd1));

    for (int n = 0; n < 200; n++) begin
      logic [31:0] x;
      x = $urandom;
      x[6:0] = OPCS[$urandom_range(0, 10)];
      apply(model(x));
    end

`ifdef IMM_DECODE_REG_EN
    // Mid-stream reset clears immediately and holds outputs clear across edges.
    apply(model(32'hFFF0_0093));
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midstream reset", zero_e);
    inst = 32'h1234_5037;
    @(posedge clk);
    #1;
    check_all("held in reset", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    prev = zero_e;
    apply(model(32'h1234_5037));
`endif

    if (sb.size() != 0) check("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
